// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous RAM with post-reset clear FSM and req/ready handshake.
// Read data lands READ_LATENCY (1 or 2) edges after acceptance; ready is low only while clearing.
// Optional PARITY_EN macro stores a parity bit per word and flags mismatches on reads.
module sync_memory #(
   parameter string FILE_NAME    = "mem_init.mif",
   parameter int    ADDR_WIDTH   = 6,
   parameter int    DATA_WIDTH   = 16,
   parameter int    CLEAR_DEPTH  = 8,
   parameter int    READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  inj_err,
   output logic                  ready,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   output logic                  parity_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] CLR_LAST = (CLEAR_DEPTH > 0) ? CNT_W'(CLEAR_DEPTH - 1) : '0;
`ifdef PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif

   generate
      if (CLEAR_DEPTH < 0 || CLEAR_DEPTH > DEPTH) begin : g_bad_clear_depth
         $error("sync_memory: CLEAR_DEPTH must be in 0..2**ADDR_WIDTH");
      end
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
         $error("sync_memory: READ_LATENCY must be 1 or 2");
      end
      if (FILE_NAME == "") begin : g_bad_file_name
         $error("sync_memory: FILE_NAME must name an init image");
      end
   endgenerate

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      clr_cnt;
   logic                  clr_we;
   logic                  acc, rd, wr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [MEM_W-1:0]      wr_word;
   logic [MEM_W-1:0]      fin_word;
   logic                  fin_vld;

   (* ram_init_file = FILE_NAME *) logic [MEM_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (clr_we) clr_cnt <= clr_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      clr_we    = 1'b0;
      if (state == CLEAR) begin
         if (CLEAR_DEPTH == 0) begin
            state_nxt = RUN;
         end else begin
            clr_we = 1'b1;
            if (clr_cnt == CLR_LAST) state_nxt = RUN;
         end
      end
   end

   assign ready   = (state == RUN);
   assign busy    = ~ready;
   assign acc     = req && ready;
   assign wr      = acc && we;
   assign rd      = acc && !we;
   assign wr_addr = clr_we ? clr_cnt[ADDR_WIDTH-1:0] : addr;

`ifdef PARITY_EN
   assign wr_word = clr_we ? '0 : {^data ^ inj_err, data};
`else
   logic unused_inj_err;
   assign unused_inj_err = inj_err;
   assign wr_word        = clr_we ? '0 : data;
`endif

   // rst wins over any clear or request write on the same edge
   always_ff @(posedge clk) begin
      if (!rst && (clr_we || wr)) mem[wr_addr] <= wr_word;
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [MEM_W-1:0] s1_word;
         logic             s1_vld;
         always_ff @(posedge clk) begin
            if (rst) s1_vld <= 1'b0;
            else     s1_vld <= rd;
            if (rd) s1_word <= mem[addr];
         end
         assign fin_vld  = s1_vld;
         assign fin_word = s1_word;
      end else begin : g_lat1
         assign fin_vld  = rd;
         assign fin_word = mem[addr];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= fin_vld;
         if (fin_vld) out <= fin_word[DATA_WIDTH-1:0];
      end
   end

`ifdef PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= fin_vld && (fin_word[DATA_WIDTH] != ^fin_word[DATA_WIDTH-1:0]);
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
